// File: rtl/dsm2_pkg.sv
// Shared constants, types and helpers for the second-order delta-sigma transmitter.
package dsm2_pkg;
    localparam int DW_DEF  = 12;
    localparam int OSR_DEF = 64;
    localparam int ACC1_W  = DW_DEF + 2;
    localparam int ACC2_W  = DW_DEF + 4;
    localparam int FS      = 1 << (DW_DEF - 1);

    // Galois mask for x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    // a+b clamped to the range of a w-bit signed number (w <= 32)
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        logic signed [32:0] s, hi, lo;
        s  = {a[31], a} + {b[31], b};
        hi = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo = -(33'sd1 <<< (w - 1));
        if (s > hi)      s = hi;
        else if (s < lo) s = lo;
        return s[31:0];
    endfunction
endpackage

// File: rtl/dsm2_if.sv
// PCM sample handshake plus bitstream outputs of the delta-sigma transmitter.
interface dsm2_if #(parameter int DW = 12);
    logic signed [DW-1:0] din;
    logic                 din_valid;
    logic                 din_ready;
    logic                 dout;
    logic                 dout_en;
    logic                 underrun;

    modport slave  (input din, din_valid, output din_ready, dout, dout_en, underrun);
    modport master (output din, din_valid, input din_ready, dout, dout_en, underrun);
endinterface

// File: rtl/dsm2_lfsr.sv
// 16-bit maximal Galois LFSR used as a +/-1 LSB dither source.
module dsm2_lfsr
    import dsm2_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_en,
    output logic [15:0] o_state
);
    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (!reset)    r_lfsr <= LFSR_SEED;
        else if (i_en) r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_POLY : 16'h0000);
    end

    assign o_state = r_lfsr;
endmodule

// File: rtl/dsm2_tx.sv
// Second-order delta-sigma modulator, PCM in / 1-bit stream out, one sample per OSR clocks.
// Define DSM2_DITHER_EN to add LFSR +/-1 LSB dither into the first integrator.
module dsm2_tx
    import dsm2_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int OSR = OSR_DEF
) (
    input logic   clk,
    input logic   reset,
    dsm2_if.slave bus
);
    localparam int A1  = DW + 2;
    localparam int A2  = DW + 4;
    localparam int CW  = $clog2(OSR);
    localparam int FSI = 1 << (DW - 1);

    state_t               r_state, w_state_nxt;
    logic signed [DW-1:0] r_cur, r_next;
    logic                 r_next_full;
    logic [CW-1:0]        r_cnt;
    logic signed [A1-1:0] r_int1, w_int1;
    logic signed [A2-1:0] r_int2, w_int2;
    logic                 r_dout, r_dout_en, r_underrun;
    logic                 w_din_ready, w_accept, w_boundary;
    int                   w_fb, w_dith;

`ifdef DSM2_DITHER_EN
    logic [15:0] w_lfsr;

    dsm2_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .i_en    (r_state == RUN),
        .o_state (w_lfsr)
    );

    assign w_dith = w_lfsr[0] ? 1 : -1;
`else
    assign w_dith = 0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // RUN is terminal; only reset leaves it
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == IDLE && w_accept) w_state_nxt = RUN;
    end

    always_comb begin
        w_din_ready = (r_state == IDLE) || !r_next_full;
    end

    assign w_accept   = bus.din_valid && w_din_ready;
    assign w_boundary = (r_cnt == CW'(OSR - 1));
    assign w_fb       = r_dout ? FSI : -FSI;
    assign w_int1     = A1'(sat_add(32'(r_int1), 32'(r_cur) - w_fb + w_dith, A1));
    assign w_int2     = A2'(sat_add(32'(r_int2), 32'(w_int1) - w_fb, A2));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cur       <= '0;
            r_next      <= '0;
            r_next_full <= 1'b0;
            r_cnt       <= '0;
            r_int1      <= '0;
            r_int2      <= '0;
            r_dout      <= 1'b0;
            r_dout_en   <= 1'b0;
            r_underrun  <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_accept) begin
                r_cur <= bus.din;
                r_cnt <= '0;
            end
            r_dout     <= 1'b0;
            r_dout_en  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_int1     <= w_int1;
            r_int2     <= w_int2;
            r_dout     <= !w_int2[A2-1];
            r_dout_en  <= 1'b1;
            r_underrun <= w_boundary && !r_next_full;
            if (w_boundary) begin
                r_cnt <= '0;
                if (r_next_full) begin
                    r_cur       <= r_next;
                    r_next_full <= 1'b0;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            // a boundary-coincident accept lands in next; cur repeats one more period
            if (w_accept) begin
                r_next      <= bus.din;
                r_next_full <= 1'b1;
            end
        end
    end

    assign bus.din_ready = w_din_ready;
    assign bus.dout      = r_dout;
    assign bus.dout_en   = r_dout_en;
    assign bus.underrun  = r_underrun;
endmodule
